// File: rtl/ethpipe_rx_slot_sched_pkg.sv
//------------------------------------------------------------------------------
// Module : ethpipe_rx_slot_sched_pkg
// Brief  : Shared widths and sizing helpers for the RX slot scheduler.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ethpipe_rx_slot_sched_pkg;

    localparam int LEN_W_DEFAULT = 11;
    localparam int TS_W_DEFAULT  = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // A single port still needs a 1-bit port field on the descriptor stream.
    function automatic int port_width(input int num_ports);
        return (num_ports <= 1) ? 1 : clog2(num_ports);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ethpipe_rx_slot_sched_rr_arb.sv
//------------------------------------------------------------------------------
// Module : ethpipe_rx_slot_sched_rr_arb
// Brief  : Combinational round-robin pick over a request vector, starting at 'start'.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ethpipe_rx_slot_sched_rr_arb #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    start,
    output logic                 grant_valid,
    output logic [PORT_W-1:0]    grant_idx,
    output logic [NUM_PORTS-1:0] grant_oh
);

    logic [PORT_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        cand        = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = PORT_W'((int'(start) + k) % NUM_PORTS);
            if (req[cand]) begin
                grant_valid    = 1'b1;
                grant_idx      = cand;
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ethpipe_rx_slot_sched.sv
//------------------------------------------------------------------------------
// Module : ethpipe_rx_slot_sched
// Brief  : N-port RX slot ring scheduler with timestamping and a round-robin
//          descriptor stream. Optional drop counters under ETHPIPE_RX_STATS_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ethpipe_rx_slot_sched
    import ethpipe_rx_slot_sched_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  SLOT_DEPTH = 4,
    parameter int  LEN_W      = LEN_W_DEFAULT,
    parameter int  TS_W       = TS_W_DEFAULT,
    localparam int PORT_W     = port_width(NUM_PORTS),
    localparam int SLOT_W     = clog2(SLOT_DEPTH)
) (
    input  logic                        pci_clk,
    input  logic                        sys_rst_n,
    input  logic                        global_counter_rst,
    output logic [TS_W-1:0]             global_counter,
    input  logic [NUM_PORTS-1:0]        rx_complete,
    input  logic [NUM_PORTS*LEN_W-1:0]  rx_len,
    output logic [NUM_PORTS*SLOT_W-1:0] rx_wr_slot,
    output logic [NUM_PORTS-1:0]        rx_slot_empty,
    output logic                        desc_valid,
    input  logic                        desc_ready,
    output logic [PORT_W-1:0]           desc_port,
    output logic [SLOT_W-1:0]           desc_slot,
    output logic [LEN_W-1:0]            desc_len,
    output logic [TS_W-1:0]             desc_ts,
    input  logic                        rel_valid,
    input  logic [PORT_W-1:0]           rel_port,
    output logic [NUM_PORTS*32-1:0]     drop_cnt
);

    localparam int PTR_W = SLOT_W + 1;

    logic [PTR_W-1:0] wr_ptr  [NUM_PORTS];
    logic [PTR_W-1:0] iss_ptr [NUM_PORTS];
    logic [PTR_W-1:0] acc_ptr [NUM_PORTS];
    logic [PTR_W-1:0] rel_ptr [NUM_PORTS];
    logic [LEN_W-1:0] len_mem [NUM_PORTS][SLOT_DEPTH];
    logic [TS_W-1:0]  ts_mem  [NUM_PORTS][SLOT_DEPTH];

    logic [NUM_PORTS-1:0] full, pending, do_wr, do_acc, do_rel, drop;
    logic                 load;
    logic                 grant_valid;
    logic [PORT_W-1:0]    grant_idx;
    logic [NUM_PORTS-1:0] grant_oh;
    logic [SLOT_W-1:0]    grant_slot;
    logic [PORT_W-1:0]    rr_start;

    // Fullness uses registered pointers only, so a same-cycle release cannot rescue a frame.
    always_comb begin
        full    = '0;
        pending = '0;
        do_wr   = '0;
        do_acc  = '0;
        do_rel  = '0;
        drop    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p]    = PTR_W'(wr_ptr[p] - rel_ptr[p]) == PTR_W'(SLOT_DEPTH);
            pending[p] = wr_ptr[p] != iss_ptr[p];
            do_wr[p]   = rx_complete[p] && !full[p];
            drop[p]    = rx_complete[p] && full[p];
            do_acc[p]  = desc_valid && desc_ready && (desc_port == PORT_W'(p));
            do_rel[p]  = rel_valid && (rel_port == PORT_W'(p)) && (rel_ptr[p] != acc_ptr[p]);
        end
    end

    assign load       = !desc_valid || desc_ready;
    assign grant_slot = iss_ptr[grant_idx][SLOT_W-1:0];

    ethpipe_rx_slot_sched_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_arb (
        .req         (pending),
        .start       (rr_start),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh)
    );

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            global_counter <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p]  <= '0;
                iss_ptr[p] <= '0;
                acc_ptr[p] <= '0;
                rel_ptr[p] <= '0;
            end
            desc_valid <= 1'b0;
            desc_port  <= '0;
            desc_slot  <= '0;
            desc_len   <= '0;
            desc_ts    <= '0;
            rr_start   <= '0;
        end else begin
            global_counter <= global_counter_rst ? '0 : global_counter + TS_W'(1);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (do_wr[p])                            wr_ptr[p]  <= wr_ptr[p]  + PTR_W'(1);
                if (do_acc[p])                           acc_ptr[p] <= acc_ptr[p] + PTR_W'(1);
                if (do_rel[p])                           rel_ptr[p] <= rel_ptr[p] + PTR_W'(1);
                if (load && grant_valid && grant_oh[p])  iss_ptr[p] <= iss_ptr[p] + PTR_W'(1);
            end
            if (load) begin
                desc_valid <= grant_valid;
                if (grant_valid) begin
                    desc_port <= grant_idx;
                    desc_slot <= grant_slot;
                    desc_len  <= len_mem[grant_idx][grant_slot];
                    desc_ts   <= ts_mem[grant_idx][grant_slot];
                    rr_start  <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + PORT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pci_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (do_wr[p]) begin
                len_mem[p][wr_ptr[p][SLOT_W-1:0]] <= rx_len[p*LEN_W +: LEN_W];
                ts_mem[p][wr_ptr[p][SLOT_W-1:0]]  <= global_counter;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rx_wr_slot[p*SLOT_W +: SLOT_W] = wr_ptr[p][SLOT_W-1:0];
        assign rx_slot_empty[p]               = !full[p];
    end

`ifdef ETHPIPE_RX_STATS_EN
    logic [31:0] drop_q [NUM_PORTS];

    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) drop_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (drop[p] && (drop_q[p] != 32'hFFFF_FFFF)) drop_q[p] <= drop_q[p] + 32'd1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_drop
        assign drop_cnt[p*32 +: 32] = drop_q[p];
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop;
    assign drop_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ethpipe_rx_slot_sched.sv
//------------------------------------------------------------------------------
// Module : tb_ethpipe_rx_slot_sched
// Brief  : Randomized + directed bench against a queue-based slot model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ethpipe_rx_slot_sched;

    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 11;
    localparam int TW    = 64;
    localparam int SW    = 2;
    localparam int PW    = 1;
`ifdef ETHPIPE_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              pci_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              global_counter_rst = 1'b0;
    logic [TW-1:0]     global_counter;
    logic [NP-1:0]     rx_complete = '0;
    logic [NP*LW-1:0]  rx_len = '0;
    logic [NP*SW-1:0]  rx_wr_slot;
    logic [NP-1:0]     rx_slot_empty;
    logic              desc_valid;
    logic              desc_ready = 1'b0;
    logic [PW-1:0]     desc_port;
    logic [SW-1:0]     desc_slot;
    logic [LW-1:0]     desc_len;
    logic [TW-1:0]     desc_ts;
    logic              rel_valid = 1'b0;
    logic [PW-1:0]     rel_port = '0;
    logic [NP*32-1:0]  drop_cnt;

    always #5 pci_clk = ~pci_clk;

    ethpipe_rx_slot_sched #(.NUM_PORTS(NP), .SLOT_DEPTH(DEPTH), .LEN_W(LW), .TS_W(TW)) dut (
        .pci_clk            (pci_clk),
        .sys_rst_n          (sys_rst_n),
        .global_counter_rst (global_counter_rst),
        .global_counter     (global_counter),
        .rx_complete        (rx_complete),
        .rx_len             (rx_len),
        .rx_wr_slot         (rx_wr_slot),
        .rx_slot_empty      (rx_slot_empty),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_port          (desc_port),
        .desc_slot          (desc_slot),
        .desc_len           (desc_len),
        .desc_ts            (desc_ts),
        .rel_valid          (rel_valid),
        .rel_port           (rel_port),
        .drop_cnt           (drop_cnt)
    );

    typedef struct packed {
        logic [PW-1:0] port;
        logic [SW-1:0] slot;
        logic [LW-1:0] len;
        logic [TW-1:0] ts;
    } desc_t;

    // Model: frames waiting for the output register, the presented one, and
    // per-port counts of slots in use and of accepted-but-unreleased slots.
    desc_t       m_waitq [NP][$];
    desc_t       m_desc;
    bit          m_valid;
    int          m_start;
    int          m_occ   [NP];
    int          m_accq  [NP];
    int          m_wslot [NP];
    int          m_drops [NP];
    logic [TW-1:0] m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_waitq[p].delete();
            m_occ[p] = 0; m_accq[p] = 0; m_wslot[p] = 0; m_drops[p] = 0;
        end
        m_desc = '0; m_valid = 0; m_start = 0; m_cnt = '0;
    endtask

    task automatic model_edge(input logic [NP-1:0] cmp, input logic [NP*LW-1:0] lens,
                              input logic rv, input logic [PW-1:0] rp,
                              input logic rdy, input logic grst);
        bit    full_pre [NP];
        bit    take;
        bit    load;
        desc_t d;
        for (int p = 0; p < NP; p++) full_pre[p] = (m_occ[p] == DEPTH);
        take = m_valid && rdy;
        load = !m_valid || rdy;
        if (rv && int'(rp) < NP && m_accq[rp] > 0) begin
            m_accq[rp]--;
            m_occ[rp]--;
        end
        if (take) m_accq[m_desc.port]++;
        if (load) begin
            m_valid = 0;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (m_start + k) % NP;
                if (!m_valid && m_waitq[p].size() > 0) begin
                    m_desc  = m_waitq[p].pop_front();
                    m_valid = 1;
                    m_start = (p + 1) % NP;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (cmp[p]) begin
                if (full_pre[p]) begin
                    m_drops[p]++;
                end else begin
                    d.port = PW'(p);
                    d.slot = SW'(m_wslot[p]);
                    d.len  = lens[p*LW +: LW];
                    d.ts   = m_cnt;
                    m_waitq[p].push_back(d);
                    m_wslot[p] = (m_wslot[p] + 1) % DEPTH;
                    m_occ[p]++;
                end
            end
        end
        m_cnt = grst ? '0 : m_cnt + 64'd1;
    endtask

    task automatic compare_all();
        check_eq("gcnt", global_counter, m_cnt);
        check_eq("dvalid", {63'd0, desc_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check_eq("dport", 64'(desc_port), 64'(m_desc.port));
            check_eq("dslot", 64'(desc_slot), 64'(m_desc.slot));
            check_eq("dlen",  64'(desc_len),  64'(m_desc.len));
            check_eq("dts",   desc_ts,        m_desc.ts);
        end
        for (int p = 0; p < NP; p++) begin
            check_eq("empty",  64'(rx_slot_empty[p]), 64'(m_occ[p] != DEPTH));
            check_eq("wrslot", 64'(rx_wr_slot[p*SW +: SW]), 64'(m_wslot[p]));
            check_eq("drop",   64'(drop_cnt[p*32 +: 32]), STATS ? 64'(m_drops[p]) : 64'd0);
        end
    endtask

    task automatic step(input logic [NP-1:0] cmp, input logic [NP*LW-1:0] lens,
                        input logic rv, input logic [PW-1:0] rp,
                        input logic rdy, input logic grst);
        rx_complete = cmp; rx_len = lens; rel_valid = rv; rel_port = rp;
        desc_ready = rdy; global_counter_rst = grst;
        model_edge(cmp, lens, rv, rp, rdy, grst);
        @(posedge pci_clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        step('0, '0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rx_complete = '0; rel_valid = 1'b0; desc_ready = 1'b0; global_counter_rst = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_gcnt",  global_counter, 64'd0);
        check_eq("rst_valid", 64'(desc_valid), 64'd0);
        check_eq("rst_desc",  64'({desc_port, desc_slot, desc_len}), 64'd0);
        check_eq("rst_ts",    desc_ts, 64'd0);
        check_eq("rst_empty", 64'(rx_slot_empty), 64'(2'b11));
        check_eq("rst_wslot", 64'(rx_wr_slot), 64'd0);
        check_eq("rst_drop",  drop_cnt, 64'd0);
        @(posedge pci_clk);
        #1;
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_step(input int p_cmp, input int p_rdy);
        logic [NP-1:0]    cmp;
        logic [NP*LW-1:0] lens;
        for (int p = 0; p < NP; p++) begin
            cmp[p] = ($urandom_range(0, 99) < p_cmp);
            lens[p*LW +: LW] = LW'($urandom_range(0, 2047));
        end
        step(cmp, lens, ($urandom_range(0, 99) < 35), PW'($urandom_range(0, NP - 1)),
             ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 199) == 0));
    endtask

    initial begin
        int guard;
        model_reset();
        do_reset();

        // One frame on port 0 stamped at count 100
        guard = 0;
        while (m_cnt != 64'd100 && guard < 200) begin idle(1'b1); guard++; end
        check_eq("t1_reach100", m_cnt, 64'd100);
        step(2'b01, {11'd0, 11'd64}, 1'b0, '0, 1'b0, 1'b0);
        check_eq("t1_wrslot", 64'(rx_wr_slot[SW-1:0]), 64'd1);
        idle(1'b0);
        check_eq("t1_valid", 64'(desc_valid), 64'd1);
        check_eq("t1_desc",  64'({desc_port, desc_slot, desc_len}), 64'({1'b0, 2'd0, 11'd64}));
        check_eq("t1_ts",    desc_ts, 64'd100);
        idle(1'b1);

        // Fill port 1, drop the fifth, release one after accept
        for (int i = 0; i < 4; i++) step(2'b10, {11'(200 + i), 11'd0}, 1'b0, '0, 1'b0, 1'b0);
        check_eq("t2_full", 64'(rx_slot_empty[1]), 64'd0);
        step(2'b10, {11'd999, 11'd0}, 1'b0, '0, 1'b0, 1'b0);
        check_eq("t2_drop", 64'(drop_cnt[63:32]), STATS ? 64'd1 : 64'd0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        step('0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t2_empty", 64'(rx_slot_empty[1]), 64'd1);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Illegal releases: nothing accepted, then a presented-but-unaccepted slot
        step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(2'b01, {11'd0, 11'd77}, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Fairness: three pending on each port, then drain with ready held high
        for (int i = 0; i < 3; i++) step(2'b11, {11'(10 + i), 11'(20 + i)}, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        for (int i = 0; i < 6; i++) step('0, '0, 1'b1, PW'(i % 2), 1'b1, 1'b0);

        // Backpressure with traffic still arriving
        for (int i = 0; i < 10; i++) rand_step(40, 0);
        for (int i = 0; i < 12; i++) idle(1'b1);

        // Counter clear at 500
        guard = 0;
        while (m_cnt != 64'd500 && guard < 1000) begin idle(1'b1); guard++; end
        check_eq("t6_reach500", m_cnt, 64'd500);
        step('0, '0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("t6_clear", global_counter, 64'd0);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            rand_step(45, 65);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
